arbitro_vc_rr: RTL

//  Round-robin scheduler that drains the four virtual-channel FIFOs (VC0..VC3)

---
 rtl/arbitro_vc_rr_if.sv | 27 ++
 rtl/arbitro_vc_rr.sv | 95 +++++++++
 2 files changed

// File: rtl/arbitro_vc_rr_if.sv
// Bundle of the VC-side, destination-side and status signals of the
// round-robin VC scheduler. master = scheduler, slave = FIFO/FSM environment.
interface arbitro_vc_rr_if #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 8
);
  logic                  active_in;
  logic [3:0]            vc_empty;
  logic [4*DATA_W-1:0]   vc_data;
  logic [1:0]            dest_afull;
  logic [3:0]            vc_pop;
  logic [1:0]            dest_push;
  logic [DATA_W-1:0]     data_out;
  logic [CNT_W-1:0]      cnt_d0;
  logic [CNT_W-1:0]      cnt_d1;
  logic                  idle_out;

  modport master (
    input  active_in, vc_empty, vc_data, dest_afull,
    output vc_pop, dest_push, data_out, cnt_d0, cnt_d1, idle_out
  );

  modport slave (
    output active_in, vc_empty, vc_data, dest_afull,
    input  vc_pop, dest_push, data_out, cnt_d0, cnt_d1, idle_out
  );
endinterface

// File: rtl/arbitro_vc_rr.sv
// Round-robin scheduler draining four VC FIFOs into two destination FIFOs,
// with a fixed two-cycle pop-to-push pipeline and per-destination counters.
module arbitro_vc_rr #(
  parameter int DATA_W   = 6,
  parameter int DEST_BIT = 5,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  arbitro_vc_rr_if.master     bus
);

  logic [3:0]        req;
  logic [3:0]        grant;
  logic [1:0]        grant_idx;
  logic [1:0]        scan_idx;
  logic              found;
  logic [1:0]        rr_ptr;

  logic [3:0]        vc_pop_p0;
  logic [1:0]        gidx_p0;
  logic [1:0]        sel_p1;
  logic              vld_p1;
  logic [DATA_W-1:0] word_p1;
  logic [1:0]        dest_push_p2;
  logic [DATA_W-1:0] data_p2;
  logic [CNT_W-1:0]  cnt_d0_q;
  logic [CNT_W-1:0]  cnt_d1_q;
  logic              idle_q;

  function automatic logic [1:0] route(input logic [DATA_W-1:0] w, input logic v);
    return v ? (w[DEST_BIT] ? 2'b10 : 2'b01) : 2'b00;
  endfunction

  // The VC popped on the previous edge still shows non-empty, so it is masked.
  always_comb begin
    req       = ~bus.vc_empty & {4{bus.active_in & ~(|bus.dest_afull)}} & ~vc_pop_p0;
    grant     = '0;
    grant_idx = rr_ptr;
    scan_idx  = rr_ptr;
    found     = 1'b0;
    for (int off = 0; off < 4; off++) begin
      scan_idx = rr_ptr + 2'(off);
      if (!found && req[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
        found           = 1'b1;
      end
    end
  end

  always_comb begin
    word_p1 = '0;
    for (int i = 0; i < 4; i++) begin
      if (sel_p1 == 2'(i)) word_p1 = bus.vc_data[i*DATA_W +: DATA_W];
    end
  end

  // p0: grant registered as pop strobe; p1: FIFO pops, select captured;
  // p2: word routed to its destination.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vc_pop_p0    <= '0;
      rr_ptr       <= 2'd0;
      vld_p1       <= 1'b0;
      dest_push_p2 <= 2'b00;
      data_p2      <= '0;
      cnt_d0_q     <= '0;
      cnt_d1_q     <= '0;
      idle_q       <= 1'b1;
    end else begin
      vc_pop_p0 <= grant;
      if (found) rr_ptr <= grant_idx + 2'd1;
      vld_p1       <= |vc_pop_p0;
      dest_push_p2 <= route(word_p1, vld_p1);
      if (vld_p1) data_p2 <= word_p1;
      cnt_d0_q <= cnt_d0_q + {{(CNT_W-1){1'b0}}, vld_p1 & ~word_p1[DEST_BIT]};
      cnt_d1_q <= cnt_d1_q + {{(CNT_W-1){1'b0}}, vld_p1 &  word_p1[DEST_BIT]};
      idle_q   <= (&bus.vc_empty) & ~(|vc_pop_p0) & ~vld_p1 & ~(|dest_push_p2);
    end
  end

  always_ff @(posedge clk) begin
    gidx_p0 <= grant_idx;
    sel_p1  <= gidx_p0;
  end

  assign bus.vc_pop    = vc_pop_p0;
  assign bus.dest_push = dest_push_p2;
  assign bus.data_out  = data_p2;
  assign bus.cnt_d0    = cnt_d0_q;
  assign bus.cnt_d1    = cnt_d1_q;
  assign bus.idle_out  = idle_q;

endmodule
